alu_lhs_seq_shifter: RTL and testbench
======================================

Name: alu_lhs_seq_shifter

Overview:
Parametrised, multi-cycle successor to the ALU left-hand-side shift stage. It accepts an operand, a shift amount and a mode over a valid/ready handshake. It then shifts or rotates the operand one bit per clock and presents the result with a carry and a zero flag over a second valid/ready handshake. The block sits between the ALU operand latch and the ALU result mux, and is clocked by the ALU clock.

Parameters:
WIDTH, 8, operand/result width in bits (>=2).
SHAMT_W, 4, width of the shift-amount port. Amounts from 0 to 2^SHAMT_W-1 are legal, including amounts >= WIDTH.

Ports:
AluClock  in  1  ALU clock; all state updates on the rising edge.
AluReset_n  in  1  reset, synchronous and active-low.
InValid  in  1  request valid.
InReady  out  1  block can accept a request (high only in IDLE).
Operand  in  WIDTH  value to shift.
Amount  in  SHAMT_W  number of single-bit steps (N).
Mode  in  3  operation select; see Behaviour.
CarryIn  in  1  fill bit for SHL/SHR.
OutValid  out  1  result valid.
OutReady  in  1  consumer accepts the result.
Result  out  WIDTH  shifted value.
CarryOut  out  1  last bit shifted or rotated out.
ZeroFlag  out  1  Result == 0.
Busy  out  1  high in SHIFT or DONE.

Behaviour:
- Mode encoding:
  - 000 PASS.
  - 001 SHL: fill LSB with CarryIn; out bit = MSB.
  - 010 SHR: fill MSB with CarryIn; out bit = LSB.
  - 011 ZERO.
  - 100 ROL: out bit = MSB.
  - 101 ROR: out bit = LSB.
  - 110 ASR: fill MSB with the current MSB; out bit = LSB.
  - 111 reserved; behaves as PASS.
- PASS, ZERO and reserved force effective N=0. PASS: Result=Operand, CarryOut=0. ZERO: Result=0, CarryOut=0.
- Mode, CarryIn and N are latched on accept. Later changes on the input ports have no effect until the next accept.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: InReady=1. Accept on InValid&&InReady at an edge. If effective N==0, load the final Result/CarryOut and go to DONE. Otherwise load the working register and go to SHIFT with count=N.
  - SHIFT: each edge performs one step and decrements count. The step when count==1 leaves for DONE. CarryOut tracks the out bit of each step, so its final value is that of step N.
  - DONE: OutValid=1; Result, CarryOut and ZeroFlag are held stable. On OutReady at an edge, go to IDLE. There is no accept in the same cycle as the DONE->IDLE transition.
- Latency: OutValid asserts after N edges following the accepting edge. For N=0 it asserts directly after the accepting edge. Throughput is one request per N+2 cycles minimum.
- N >= WIDTH:
  - Shifts continue stepping; a result of all fill bits is legal.
  - Rotates wrap naturally, giving an effective N mod WIDTH. The CarryOut value is still that of step N.
- ZeroFlag is computed from the registered Result and is valid whenever OutValid=1.
- Reset (AluReset_n=0 at an edge): state=IDLE, count=0, Result=0, CarryOut=0, ZeroFlag=1, OutValid=0, Busy=0, InReady=1 from the following cycle.
- Reset mid-SHIFT or mid-DONE discards the operation; no OutValid is produced for it.
- Inputs are ignored outside IDLE; InValid while Busy is not an error, the request simply waits.
- Result, CarryOut and ZeroFlag are undefined-free: they keep their last values while in IDLE and SHIFT. Only DONE qualifies them.

Test Plan:
1. Reset then idle: AluReset_n low 2 edges -> InReady=1, OutValid=0, Result=0x00, ZeroFlag=1, Busy=0.
2. SHL, Operand=0x81, N=1, CarryIn=0 -> OutValid 1 edge after accept, Result=0x02, CarryOut=1. SHR of the same operand -> Result=0x40, CarryOut=1.
3. ASR, 0x80, N=3 -> Result=0xF0, CarryOut=0 after 3 edges. ROL, 0x81, N=4 -> 0x18, CarryOut=0. ROR, 0x01, N=9 -> 0x80, CarryOut=1 after 9 edges.
4. Large shifts and PASS/ZERO:
   - SHL, 0x00, N=10, CarryIn=1 -> 0xFF, CarryOut=1.
   - PASS, 0x08, N=5 -> 0x08 immediately after accept, CarryOut=0.
   - ZERO, 0x08 -> 0x00, ZeroFlag=1.
5. Backpressure: SHL result pending with OutReady low for 5 cycles -> OutValid, Result and CarryOut held constant and InReady=0. A new InValid during the hold is not accepted until the cycle after OutReady.
6. Reset mid-operation: ROL, N=12, AluReset_n low on the 4th SHIFT edge -> next cycle IDLE, OutValid never asserts for that request. A following SHL, 0x01, N=1 -> 0x02.

Source files
------------

// File: rtl/alu_lhs_seq_shifter.sv
// ---------------------------------------------------------------------------
// alu_lhs_seq_shifter
// Multi-cycle ALU left-hand-side shift stage. Accepts an operand, a shift
// amount and a mode over a valid/ready handshake. It then shifts or rotates
// the operand one bit per clock. It presents Result, CarryOut and ZeroFlag
// over a second valid/ready handshake.
//
// Ports
//   AluClock    in   ALU clock, rising edge
//   AluReset_n  in   synchronous active-low reset
//   InValid     in   request valid
//   InReady     out  request can be accepted (IDLE only)
//   Operand     in   [WIDTH]   value to shift
//   Amount      in   [SHAMT_W] number of single-bit steps
//   Mode        in   [3]       000 PASS, 001 SHL, 010 SHR, 011 ZERO,
//                              100 ROL, 101 ROR, 110 ASR, 111 PASS
//   CarryIn     in   fill bit for SHL/SHR
//   OutValid    out  result valid (DONE)
//   OutReady    in   consumer accepts the result
//   Result      out  [WIDTH] shifted value
//   CarryOut    out  last bit shifted/rotated out
//   ZeroFlag    out  Result == 0
//   Busy        out  SHIFT or DONE
// ---------------------------------------------------------------------------
module alu_lhs_seq_shifter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic               AluClock,
  input  logic               AluReset_n,
  input  logic               InValid,
  output logic               InReady,
  input  logic [WIDTH-1:0]   Operand,
  input  logic [SHAMT_W-1:0] Amount,
  input  logic [2:0]         Mode,
  input  logic               CarryIn,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [WIDTH-1:0]   Result,
  output logic               CarryOut,
  output logic               ZeroFlag,
  output logic               Busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] M_PASS = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_ZERO = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_RSVD = 3'b111;

  state_t               r_state;
  state_t               w_next;
  logic [SHAMT_W-1:0]   r_count;
  logic [2:0]           r_mode;
  logic                 r_cin;
  logic [WIDTH-1:0]     r_work;
  logic [WIDTH-1:0]     r_result;
  logic                 r_carry;

  logic                 w_accept;
  logic                 w_noshift;
  logic                 w_last;
  logic [WIDTH:0]       w_step;

  // One single-bit step: returns {out_bit, next_value}.
  function automatic logic [WIDTH:0] f_step(input logic [WIDTH-1:0] v,
                                            input logic [2:0]       m,
                                            input logic             cin);
    logic [WIDTH:0] s;
    s = {1'b0, v};
    case (m)
      M_SHL:   s = {v[WIDTH-1], v[WIDTH-2:0], cin};
      M_SHR:   s = {v[0], cin, v[WIDTH-1:1]};
      M_ROL:   s = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      M_ROR:   s = {v[0], v[0], v[WIDTH-1:1]};
      M_ASR:   s = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: s = {1'b0, v};
    endcase
    return s;
  endfunction

  assign w_accept  = InValid && (r_state == S_IDLE);
  // PASS, ZERO and the reserved code never step; a zero amount also finishes
  // immediately with the operand unchanged.
  assign w_noshift = (Mode == M_PASS) || (Mode == M_ZERO) ||
                     (Mode == M_RSVD) || (Amount == '0);
  assign w_last    = (r_count == SHAMT_W'(1));
  assign w_step    = f_step(r_work, r_mode, r_cin);

  always_ff @(posedge AluClock) begin
    if (!AluReset_n) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_noshift ? S_DONE : S_SHIFT;
      S_SHIFT: if (w_last)   w_next = S_DONE;
      S_DONE:  if (OutReady) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Working register steps every SHIFT cycle; the visible Result/CarryOut
  // only change when the final value is known, so they hold in IDLE/SHIFT.
  always_ff @(posedge AluClock) begin
    if (!AluReset_n) begin
      r_count  <= '0;
      r_mode   <= M_PASS;
      r_cin    <= 1'b0;
      r_work   <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mode <= Mode;
            r_cin  <= CarryIn;
            r_work <= Operand;
            if (w_noshift) begin
              r_count  <= '0;
              r_result <= (Mode == M_ZERO) ? '0 : Operand;
              r_carry  <= 1'b0;
            end else begin
              r_count  <= Amount;
            end
          end
        end
        S_SHIFT: begin
          r_work  <= w_step[WIDTH-1:0];
          r_count <= r_count - SHAMT_W'(1);
          if (w_last) begin
            r_result <= w_step[WIDTH-1:0];
            r_carry  <= w_step[WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign InReady  = (r_state == S_IDLE);
  assign OutValid = (r_state == S_DONE);
  assign Busy     = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign Result   = r_result;
  assign CarryOut = r_carry;
  assign ZeroFlag = (r_result == '0);

endmodule

// File: tb/tb_alu_lhs_seq_shifter.sv
// ---------------------------------------------------------------------------
// tb_alu_lhs_seq_shifter
// Self-checking bench: directed cases followed by random requests, each
// compared against an arithmetic reference model of the shift/rotate rules.
// ---------------------------------------------------------------------------
module tb_alu_lhs_seq_shifter;

  localparam int W  = 8;
  localparam int SW = 4;

  logic          AluClock;
  logic          AluReset_n;
  logic          InValid;
  logic          InReady;
  logic [W-1:0]  Operand;
  logic [SW-1:0] Amount;
  logic [2:0]    Mode;
  logic          CarryIn;
  logic          OutValid;
  logic          OutReady;
  logic [W-1:0]  Result;
  logic          CarryOut;
  logic          ZeroFlag;
  logic          Busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_lhs_seq_shifter #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .AluClock   (AluClock),
    .AluReset_n (AluReset_n),
    .InValid    (InValid),
    .InReady    (InReady),
    .Operand    (Operand),
    .Amount     (Amount),
    .Mode       (Mode),
    .CarryIn    (CarryIn),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .Result     (Result),
    .CarryOut   (CarryOut),
    .ZeroFlag   (ZeroFlag),
    .Busy       (Busy)
  );

  initial AluClock = 1'b0;
  always #5 AluClock = ~AluClock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: whole-operation arithmetic on a wide value (no stepping).
  task automatic model(input logic [2:0] m, input logic [W-1:0] op, input int n,
                       input logic cin, output logic [W-1:0] res,
                       output logic c, output int en);
    logic [63:0] x;
    logic        fill;
    int          r;
    en  = (m == 3'b000 || m == 3'b011 || m == 3'b111) ? 0 : n;
    res = op;
    c   = 1'b0;
    r   = en % W;
    if (m == 3'b011) res = '0;
    else if (en != 0) begin
      case (m)
        3'b001: begin
          x   = (64'(op) << en) | (cin ? ((64'd1 << en) - 64'd1) : 64'd0);
          res = x[W-1:0];
          c   = x[W];
        end
        3'b010, 3'b110: begin
          fill = (m == 3'b110) ? op[W-1] : cin;
          x    = 64'(op) | (fill ? (((64'd1 << en) - 64'd1) << W) : 64'd0);
          res  = W'(x >> en);
          c    = x[en-1];
        end
        3'b100: begin
          x   = (64'(op) << r) | (64'(op) >> (W - r));
          res = x[W-1:0];
          c   = res[0];
        end
        3'b101: begin
          x   = (64'(op) >> r) | (64'(op) << (W - r));
          res = x[W-1:0];
          c   = res[W-1];
        end
        default: ;
      endcase
    end
  endtask

  // Called and returns just after a falling edge with the DUT in IDLE.
  task automatic do_op(input logic [2:0] m, input logic [W-1:0] op, input int n,
                       input logic cin, input int hold);
    logic [W-1:0] e_res;
    logic         e_c;
    int           e_n;
    int           cnt;
    model(m, op, n, cin, e_res, e_c, e_n);
    InValid = 1'b1;
    Mode    = m;
    Operand = op;
    Amount  = SW'(n);
    CarryIn = cin;
    chk("in_ready", InReady, 1);
    @(posedge AluClock); @(negedge AluClock);
    // Scramble inputs: the DUT must use the values latched at accept.
    InValid = 1'b0;
    Mode    = 3'($urandom);
    Operand = W'($urandom);
    Amount  = SW'($urandom);
    CarryIn = 1'($urandom);
    cnt = 0;
    while (!OutValid && cnt < 40) begin
      @(posedge AluClock); @(negedge AluClock);
      cnt++;
    end
    chk("latency", cnt, e_n);
    chk("result", Result, e_res);
    chk("carry", CarryOut, e_c);
    chk("zero", ZeroFlag, (e_res == '0));
    chk("busy_done", Busy, 1);
    chk("rdy_done", InReady, 0);
    for (int i = 0; i < hold; i++) begin
      InValid = 1'b1;
      Mode    = 3'($urandom);
      Operand = W'($urandom);
      Amount  = SW'($urandom);
      @(posedge AluClock); @(negedge AluClock);
      chk("hold_valid", OutValid, 1);
      chk("hold_result", Result, e_res);
      chk("hold_carry", CarryOut, e_c);
      chk("hold_rdy", InReady, 0);
    end
    OutReady = 1'b1;
    @(posedge AluClock); @(negedge AluClock);
    OutReady = 1'b0;
    // InValid may have been high across the release edge: it must not be taken.
    chk("rel_valid", OutValid, 0);
    chk("rel_rdy", InReady, 1);
    chk("rel_busy", Busy, 0);
    chk("idle_result", Result, e_res);
    InValid = 1'b0;
  endtask

  initial begin
    logic seen;
    AluReset_n = 1'b0;
    InValid    = 1'b0;
    OutReady   = 1'b0;
    Operand    = '0;
    Amount     = '0;
    Mode       = '0;
    CarryIn    = 1'b0;
    @(negedge AluClock);
    @(posedge AluClock); @(posedge AluClock); @(negedge AluClock);
    AluReset_n = 1'b1;
    chk("rst_rdy", InReady, 1);
    chk("rst_valid", OutValid, 0);
    chk("rst_result", Result, 0);
    chk("rst_zero", ZeroFlag, 1);
    chk("rst_busy", Busy, 0);

    do_op(3'b001, 8'h81, 1, 1'b0, 0);   // SHL -> 0x02 c1
    do_op(3'b010, 8'h81, 1, 1'b0, 0);   // SHR -> 0x40 c1
    do_op(3'b110, 8'h80, 3, 1'b0, 0);   // ASR -> 0xF0 c0
    do_op(3'b100, 8'h81, 4, 1'b0, 0);   // ROL -> 0x18 c0
    do_op(3'b101, 8'h01, 9, 1'b0, 0);   // ROR -> 0x80 c1
    do_op(3'b001, 8'h00, 10, 1'b1, 0);  // SHL fill -> 0xFF c1
    do_op(3'b000, 8'h08, 5, 1'b0, 0);   // PASS
    do_op(3'b011, 8'h08, 5, 1'b1, 0);   // ZERO
    do_op(3'b111, 8'h5A, 7, 1'b1, 0);   // reserved acts as PASS
    do_op(3'b001, 8'h33, 2, 1'b1, 5);   // backpressure hold

    // Reset on the 4th SHIFT edge of a long rotate.
    InValid = 1'b1; Mode = 3'b100; Operand = 8'hA5; Amount = 4'd12; CarryIn = 1'b0;
    @(posedge AluClock); @(negedge AluClock);
    InValid = 1'b0;
    repeat (3) begin @(posedge AluClock); @(negedge AluClock); end
    AluReset_n = 1'b0;
    @(posedge AluClock); @(negedge AluClock);
    AluReset_n = 1'b1;
    chk("mid_rst_rdy", InReady, 1);
    chk("mid_rst_valid", OutValid, 0);
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_result", Result, 0);
    seen = 1'b0;
    repeat (15) begin
      @(posedge AluClock); @(negedge AluClock);
      seen = seen | OutValid;
    end
    chk("mid_rst_ghost", seen, 0);
    do_op(3'b001, 8'h01, 1, 1'b0, 0);   // SHL -> 0x02

    for (int k = 0; k < 40; k++)
      do_op(3'($urandom), W'($urandom), int'($urandom_range(0, 15)),
            1'($urandom), int'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
